// File: rtl/piso_bit_serializer_pkg.sv
// Shared types and constants for the PISO bit serializer feeding the 11011 detector.
package piso_bit_serializer_pkg;

  typedef enum logic [0:0] {
    StIdle,
    StShift
  } piso_state_e;

  localparam logic IdleBitDefault = 1'b0;

  // Counter width for a WIDTH-bit word; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/piso_hold_reg.sv
// One-entry holding register: accepts a word on in_valid && in_ready, releases it on take.
module piso_hold_reg #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             take,
  output logic [WIDTH-1:0] data,
  output logic             full
);

  logic accept;

  assign in_ready = !full;
  assign accept   = in_valid && in_ready;

  // take needs full=1 and accept needs full=0, so they never coincide.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full <= 1'b0;
    end else if (take) begin
      full <= 1'b0;
    end else if (accept) begin
      full <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      data <= in_data;
    end
  end

endmodule

// File: rtl/piso_bit_serializer.sv
// Double-buffered parallel-in/serial-out stage; one bit per clk, gapless across held words.
module piso_bit_serializer
  import piso_bit_serializer_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1,
  parameter logic        IDLE_BIT  = IdleBitDefault
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             dout,
  output logic             dout_valid,
  output logic             sof,
  output logic             busy,
  output logic             underrun
);

  localparam int unsigned CntW = cnt_width(WIDTH);

  if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
    $error("piso_bit_serializer: WIDTH must be in 2..32");
  end

  piso_state_e      state_q;
  logic [CntW-1:0]  cnt_q;
  logic [WIDTH-1:0] shift_q;
  logic [WIDTH-1:0] hold_data;
  logic             hold_full;
  logic             last_bit;
  logic             take;

  function automatic logic first_bit(input logic [WIDTH-1:0] word);
    return MSB_FIRST ? word[WIDTH-1] : word[0];
  endfunction

  function automatic logic [WIDTH-1:0] drop_bit(input logic [WIDTH-1:0] word);
    return MSB_FIRST ? {word[WIDTH-2:0], 1'b0} : {1'b0, word[WIDTH-1:1]};
  endfunction

  piso_hold_reg #(
    .WIDTH(WIDTH)
  ) u_hold (
    .clk     (clk),
    .rst     (rst),
    .in_data (in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .take    (take),
    .data    (hold_data),
    .full    (hold_full)
  );

  // cnt_q is the index of the bit currently on dout.
  assign last_bit = (cnt_q == CntW'(WIDTH - 1));
  assign take     = hold_full && ((state_q == StIdle) || last_bit);
  assign busy     = (state_q == StShift) || hold_full;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      shift_q    <= '0;
      dout       <= IDLE_BIT;
      dout_valid <= 1'b0;
      sof        <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      sof      <= 1'b0;
      underrun <= 1'b0;
      if (take) begin
        // shift_q keeps only the bits not yet on dout.
        state_q    <= StShift;
        cnt_q      <= '0;
        shift_q    <= drop_bit(hold_data);
        dout       <= first_bit(hold_data);
        dout_valid <= 1'b1;
        sof        <= 1'b1;
      end else if (state_q == StShift && !last_bit) begin
        cnt_q   <= cnt_q + CntW'(1);
        shift_q <= drop_bit(shift_q);
        dout    <= first_bit(shift_q);
      end else if (state_q == StShift) begin
        state_q    <= StIdle;
        cnt_q      <= '0;
        dout       <= IDLE_BIT;
        dout_valid <= 1'b0;
        underrun   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_piso_bit_serializer.sv
// Three serializer configurations driven by random words and checked against a bit-stream model.
module tb_piso_bit_serializer;

  localparam int NL = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] din  [NL];
  logic        vin  [NL];
  logic        rdy  [NL];
  logic        dout [NL];
  logic        dv   [NL];
  logic        sof  [NL];
  logic        bsy  [NL];
  logic        und  [NL];

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: bits still to emit after the one on dout, plus the held word.
  logic        e_dout [NL];
  logic        e_dv   [NL];
  logic        e_sof  [NL];
  logic        e_und  [NL];
  logic [31:0] rem    [NL];
  int          rem_n  [NL];
  logic [31:0] hw     [NL];
  bit          hf     [NL];

  logic [31:0] src_w [NL][32];
  int          src_n [NL];
  int          src_i [NL];
  bit          cont  [NL];

  always #5 clk = ~clk;

  piso_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_dut0 (
    .clk(clk), .rst(rst), .in_data(din[0][7:0]), .in_valid(vin[0]), .in_ready(rdy[0]),
    .dout(dout[0]), .dout_valid(dv[0]), .sof(sof[0]), .busy(bsy[0]), .underrun(und[0])
  );

  piso_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_dut1 (
    .clk(clk), .rst(rst), .in_data(din[1][7:0]), .in_valid(vin[1]), .in_ready(rdy[1]),
    .dout(dout[1]), .dout_valid(dv[1]), .sof(sof[1]), .busy(bsy[1]), .underrun(und[1])
  );

  piso_bit_serializer #(.WIDTH(2), .MSB_FIRST(1'b1)) u_dut2 (
    .clk(clk), .rst(rst), .in_data(din[2][1:0]), .in_valid(vin[2]), .in_ready(rdy[2]),
    .dout(dout[2]), .dout_valid(dv[2]), .sof(sof[2]), .busy(bsy[2]), .underrun(und[2])
  );

  function automatic int lane_w(input int l);
    return (l == 2) ? 2 : 8;
  endfunction

  function automatic bit lane_msb(input int l);
    return (l != 1);
  endfunction

  // Bit i of the result is the i-th bit to appear on dout.
  function automatic logic [31:0] emit_order(input int l, input logic [31:0] word);
    logic [31:0] s;
    s = '0;
    for (int i = 0; i < lane_w(l); i++) begin
      s[i] = lane_msb(l) ? word[lane_w(l) - 1 - i] : word[i];
    end
    return s;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int l = 0; l < NL; l++) begin
      e_dout[l] = 1'b0;
      e_dv[l]   = 1'b0;
      e_sof[l]  = 1'b0;
      e_und[l]  = 1'b0;
      rem[l]    = '0;
      rem_n[l]  = 0;
      hf[l]     = 1'b0;
      vin[l]    = 1'b0;
      din[l]    = '0;
    end
  endtask

  task automatic clear_src();
    for (int l = 0; l < NL; l++) begin
      src_n[l] = 0;
      src_i[l] = 0;
      cont[l]  = 1'b1;
    end
  endtask

  task automatic add_word(input int l, input logic [31:0] w);
    src_w[l][src_n[l]] = w;
    src_n[l]++;
  endtask

  task automatic check_all();
    for (int l = 0; l < NL; l++) begin
      check_eq($sformatf("L%0d dout", l), dout[l], e_dout[l]);
      check_eq($sformatf("L%0d dout_valid", l), dv[l], e_dv[l]);
      check_eq($sformatf("L%0d sof", l), sof[l], e_sof[l]);
      check_eq($sformatf("L%0d underrun", l), und[l], e_und[l]);
      check_eq($sformatf("L%0d in_ready", l), rdy[l], !hf[l]);
      check_eq($sformatf("L%0d busy", l), bsy[l], e_dv[l] || hf[l]);
    end
  endtask

  // Drive inputs for the coming edge and advance the model across it.
  task automatic drive_step();
    bit          go;
    bit          acc;
    logic [31:0] s;
    for (int l = 0; l < NL; l++) begin
      go     = (src_i[l] < src_n[l]) && (cont[l] || $urandom_range(0, 2) != 0);
      vin[l] = go;
      din[l] = (go && !hf[l]) ? src_w[l][src_i[l]] : $urandom();
      acc    = go && !hf[l];
      if (e_dv[l] && rem_n[l] > 0) begin
        e_dout[l] = rem[l][0];
        rem[l]    = rem[l] >> 1;
        rem_n[l]--;
        e_sof[l]  = 1'b0;
        e_und[l]  = 1'b0;
      end else if (hf[l]) begin
        s         = emit_order(l, hw[l]);
        e_dout[l] = s[0];
        rem[l]    = s >> 1;
        rem_n[l]  = lane_w(l) - 1;
        e_dv[l]   = 1'b1;
        e_sof[l]  = 1'b1;
        e_und[l]  = 1'b0;
        hf[l]     = 1'b0;
      end else begin
        e_und[l]  = e_dv[l];
        e_dv[l]   = 1'b0;
        e_sof[l]  = 1'b0;
        e_dout[l] = 1'b0;
      end
      if (acc) begin
        hw[l] = din[l] & ((32'h1 << lane_w(l)) - 32'h1);
        hf[l] = 1'b1;
        src_i[l]++;
      end
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    check_all();
    drive_step();
  endtask

  task automatic run_until_drained(input int budget);
    bit drained;
    drained = 1'b0;
    for (int c = 0; c < budget && !drained; c++) begin
      cycle();
      drained = 1'b1;
      for (int l = 0; l < NL; l++) begin
        if (src_i[l] < src_n[l] || hf[l] || e_dv[l] || e_und[l]) drained = 1'b0;
      end
    end
    check_eq("drain", drained, 1);
    for (int c = 0; c < 3; c++) cycle();
  endtask

  initial begin
    bit found;
    model_reset();
    clear_src();

    @(negedge clk);
    check_all();
    rst = 1'b0;
    drive_step();
    for (int c = 0; c < 2; c++) cycle();

    // Single words on each lane; back-to-back narrow words on lane 2.
    add_word(0, 32'hDB);
    add_word(1, 32'h1B);
    add_word(2, 32'h3);
    add_word(2, 32'h1);
    add_word(2, 32'h2);
    run_until_drained(60);

    // Streaming with in_valid held (random data while the holding register is full).
    clear_src();
    add_word(0, 32'hFF);
    add_word(0, 32'h00);
    add_word(0, 32'hA5);
    cont[1] = 1'b0;
    for (int i = 0; i < 12; i++) add_word(1, $urandom());
    for (int i = 0; i < 12; i++) add_word(2, $urandom());
    run_until_drained(200);

    // Asynchronous reset while bit 3 of 8'hDB is on dout.
    clear_src();
    add_word(0, 32'hDB);
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      cycle();
      found = e_dv[0] && rem_n[0] == 4;
    end
    check_eq("reach bit 3", found, 1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check_eq("rst dout", dout[0], 0);
    check_eq("rst dout_valid", dv[0], 0);
    model_reset();
    clear_src();
    check_all();
    @(negedge clk);
    rst = 1'b0;
    check_all();
    add_word(0, 32'h5A);
    drive_step();
    run_until_drained(60);

    // Random traffic with random gaps on every lane.
    clear_src();
    for (int l = 0; l < NL; l++) begin
      cont[l] = $urandom_range(0, 1) != 0;
      for (int i = 0; i < 25; i++) add_word(l, $urandom());
    end
    run_until_drained(800);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/piso_bit_serializer.md
Name: piso_bit_serializer

Overview:
- Parallel-in/serial-out stage sitting directly upstream of the serial pattern detector (fsm_mealy_11011).
- Accepts WIDTH-bit words over a valid/ready handshake and emits one bit per clk on dout.
- Double-buffered: back-to-back words stream with no gap bits. When starved, it drives IDLE_BIT so the detector sees a defined idle level.

Parameters:
- WIDTH, 8, word width in bits; legal range 2..32.
- MSB_FIRST, 1, 1 = bit WIDTH-1 is sent first; 0 = bit 0 is sent first.
- IDLE_BIT, 1'b0, value driven on dout while no word is shifting.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; asynchronous, active-high.
- in_data  in  WIDTH  parallel word.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  holding register is empty; word is accepted on an edge where in_valid && in_ready.
- dout  out  1  serial bit, registered; feeds detector din.
- dout_valid  out  1  dout carries a data bit this cycle.
- sof  out  1  high with the first bit of each word.
- busy  out  1  shifter active, or holding register full.
- underrun  out  1  one-cycle pulse when the stream drains: last bit sent and no next word is held.

Behaviour:
- Reset (async assert, any time, including mid-word):
  - state=IDLE, hold_full=0, bit counter=0.
  - dout=IDLE_BIT; dout_valid=0, sof=0, underrun=0.
  - Shifter and hold contents are don't-care; a partial word is discarded.
  - in_ready=1 immediately after reset release.
- in_ready = !hold_full (combinational, no bypass).
  - A word is accepted on a rising edge with in_valid && in_ready. in_data is captured into hold and hold_full is set.
  - in_valid while in_ready=0 is ignored. The sender must hold the word until it is accepted.
- States:
  - IDLE:
    - If hold_full at an edge: load shifter from hold, clear hold_full, cnt=0, go SHIFT.
    - The first bit appears on dout with dout_valid=1 and sof=1 after that same edge.
    - Latency: word accepted at edge N -> first bit registered at edge N+1.
  - SHIFT:
    - Each edge outputs the next bit (MSB or LSB per MSB_FIRST) and increments cnt.
    - At the edge following the last bit (cnt==WIDTH-1) with hold_full=1: reload from hold, clear hold_full, cnt=0, sof=1. Stay in SHIFT; no gap cycle.
    - At the same point with hold_full=0: go IDLE, dout=IDLE_BIT, dout_valid=0, underrun=1 for one cycle.
- Simultaneous events:
  - Hold emptied at an edge: in_ready was 0 at that edge, so no same-edge write. A new word can be accepted from the next edge.
  - WIDTH>=2 guarantees the refill reaches hold before the next reload, so streaming is gapless if the sender keeps in_valid high.
- Word boundaries:
  - Bits are continuous across words, so detector patterns spanning words are visible.
  - After an underrun, IDLE_BIT cycles separate the streams.
- busy = (state==SHIFT) || hold_full.
- in_data is not stored unless accepted; X on in_data while in_valid=0 has no effect.

Decomposition:
- Shared package: state encoding (IDLE, SHIFT), the counter width constant $clog2(WIDTH), and the IDLE_BIT default.
- One natural sub-module: piso_hold_reg (one-entry holding register with valid/ready). The shifter and control stay in the top.

Test Plan:
- Reset then single word 8'hDB, MSB_FIRST=1:
  - dout = 1,1,0,1,1,0,1,1 on 8 consecutive cycles starting one edge after acceptance.
  - sof on bit 0 only.
  - underrun pulse after bit 7, then dout=0, dout_valid=0.
  - Feeding the detector gives exactly one dout pulse on bit 4.
- Back-to-back 8'hFF, 8'h00, 8'hA5 with in_valid held high:
  - 24 contiguous valid bits, no gap.
  - sof at cycles 0, 8, 16.
  - in_ready low exactly while hold is full.
  - Single underrun after the last bit.
- MSB_FIRST=0 with 8'h1B: dout = 1,1,0,1,1,0,0,0.
- in_valid asserted while in_ready=0 with a different value each cycle: only the value present at the accepting edge is serialized; no word is lost or duplicated.
- Assert rst at bit 3 of 8'hDB: on the same cycle dout=IDLE_BIT and dout_valid=0. After release, in_ready=1 and a new 8'h5A serializes fully from bit 0.
- WIDTH=2 stress:
  - Continuous in_valid with words 2'b11, 2'b01, 2'b10 -> dout 1,1,0,1,1,0 gapless.
  - No underrun until the stream stops.
